// File: rtl/flash_bitstream_streamer_pkg.sv
// Shared flash-access definitions: SPI opcodes,
// command length and streamer state encodings.
package flash_bitstream_streamer_pkg;

  localparam logic [7:0] SPI_READ = 8'h03;
  localparam int unsigned CMD_BITS = 32;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARMED  = 3'd1,
    S_CMD    = 3'd2,
    S_DATA   = 3'd3,
    S_FINISH = 3'd4
  } state_e;

endpackage

// File: rtl/flash_bitstream_streamer_spi_cmd_shifter.sv
// 32-bit parallel-load MSB-first command shifter.
// done_o rises once all bits have been shifted out.
module spi_cmd_shifter
  import flash_bitstream_streamer_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic [31:0] data_i,
  input  logic        shift_i,
  output logic        msb_o,
  output logic        done_o
);

  logic [31:0] sr_q;
  logic [5:0]  cnt_q;

  assign msb_o  = sr_q[31];
  assign done_o = (cnt_q == 6'(CMD_BITS));

  // Load clears the bit count; each shift emits one bit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      sr_q  <= data_i;
      cnt_q <= '0;
    end else if (shift_i && !done_o) begin
      sr_q  <= {sr_q[30:0], 1'b0};
      cnt_q <= cnt_q + 6'd1;
    end
  end

endmodule

// File: rtl/flash_bitstream_streamer.sv
// Flash-side bitstream streamer: sends a SPI READ,
// then forwards flash data one bit per clk.
module flash_bitstream_streamer
  import flash_bitstream_streamer_pkg::*;
#(
  parameter logic [23:0] START_ADDR     = 24'hCE0000,
  parameter logic [31:0] BITSTREAM_BITS = 32'd6_000_000,
  parameter logic [7:0]  READ_CMD       = SPI_READ
) (
  input  logic clk,
  input  logic reset,
  input  logic store_flash_command,
  input  logic read_bitstream,
  input  logic prog_chan_in_progress,
  output logic bitstream,
  output logic end_bitstream,
  output logic spi_cs_n,
  output logic spi_sck,
  output logic spi_mosi,
  input  logic spi_miso,
  output logic stream_abort
);

  state_e      state_q, state_d;
  logic        cs_n_q, cs_n_d;
  logic        sck_en_q, sck_en_d;
  logic        mosi_q, mosi_d;
  logic        bit_q, bit_d;
  logic        end_q, end_d;
  logic        abort_q, abort_d;
  logic [31:0] cnt_q, cnt_d;
  logic        sh_load, sh_shift;
  logic        sh_msb, sh_done;
  logic        abort_req;
  logic        last_bit;

  spi_cmd_shifter u_shifter (
    .clk_i  (clk),
    .rst_i  (reset),
    .load_i (sh_load),
    .data_i ({READ_CMD, START_ADDR}),
    .shift_i(sh_shift),
    .msb_o  (sh_msb),
    .done_o (sh_done)
  );

  assign last_bit = (cnt_q == BITSTREAM_BITS - 32'd1);

  assign abort_req =
    (!read_bitstream &&
     (state_q == S_CMD || state_q == S_DATA)) ||
    (!prog_chan_in_progress &&
     (state_q == S_ARMED || state_q == S_CMD ||
      state_q == S_DATA));

  assign bitstream     = bit_q;
  assign end_bitstream = end_q;
  assign spi_cs_n      = cs_n_q;
  assign spi_mosi      = mosi_q;
  assign stream_abort  = abort_q;
  assign spi_sck       = ~clk & sck_en_q;

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cs_n_q   <= 1'b1;
      sck_en_q <= 1'b0;
      mosi_q   <= 1'b0;
      bit_q    <= 1'b1;
      end_q    <= 1'b0;
      abort_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      cs_n_q   <= cs_n_d;
      sck_en_q <= sck_en_d;
      mosi_q   <= mosi_d;
      bit_q    <= bit_d;
      end_q    <= end_d;
      abort_q  <= abort_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next state; abort overrides every other transition.
  always_comb begin
    state_d  = state_q;
    cs_n_d   = cs_n_q;
    sck_en_d = sck_en_q;
    mosi_d   = 1'b0;
    bit_d    = 1'b1;
    end_d    = 1'b0;
    abort_d  = abort_q;
    cnt_d    = cnt_q;
    sh_load  = 1'b0;
    sh_shift = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cs_n_d   = 1'b1;
        sck_en_d = 1'b0;
        if (store_flash_command) begin
          sh_load = 1'b1;
          abort_d = 1'b0;
          state_d = S_ARMED;
        end
      end
      S_ARMED: begin
        cs_n_d   = 1'b1;
        sck_en_d = 1'b0;
        cnt_d    = '0;
        if (read_bitstream) begin
          state_d  = S_CMD;
          cs_n_d   = 1'b0;
          sck_en_d = 1'b1;
          sh_shift = 1'b1;
          mosi_d   = sh_msb;
        end
      end
      S_CMD: begin
        if (sh_done) begin
          state_d = S_DATA;
        end else begin
          sh_shift = 1'b1;
          mosi_d   = sh_msb;
        end
      end
      S_DATA: begin
        bit_d = spi_miso;
        cnt_d = cnt_q + 32'd1;
        if (last_bit) begin
          end_d   = 1'b1;
          state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        cs_n_d   = 1'b1;
        sck_en_d = 1'b0;
        if (!read_bitstream) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort_req) begin
      state_d  = S_IDLE;
      cs_n_d   = 1'b1;
      sck_en_d = 1'b0;
      mosi_d   = 1'b0;
      bit_d    = 1'b1;
      end_d    = 1'b0;
      abort_d  = 1'b1;
      sh_shift = 1'b0;
    end
  end

endmodule

// File: tb/tb_flash_bitstream_streamer.sv
// Randomized bench for flash_bitstream_streamer
// with a SPI flash model and waveform reference.
module tb_flash_bitstream_streamer;

  localparam logic [31:0] CMD_WORD = 32'h03CE0000;

  logic clk = 1'b0;
  logic reset, store, rd, prog;
  logic miso = 1'b0;
  logic a_bit, a_end, a_cs_n, a_sck, a_mosi, a_abort;
  logic b_bit, b_end, b_cs_n, b_sck, b_mosi, b_abort;

  int errs = 0;
  int checks = 0;
  logic [15:0] fdata = 16'hA5C3;
  logic [31:0] cmdw = CMD_WORD;
  logic [31:0] fcmd = '0;
  int ncap = 0;
  int didx = 0;

  flash_bitstream_streamer #(
    .BITSTREAM_BITS(32'd16)
  ) dut_a (
    .clk                  (clk),
    .reset                (reset),
    .store_flash_command  (store),
    .read_bitstream       (rd),
    .prog_chan_in_progress(prog),
    .bitstream            (a_bit),
    .end_bitstream        (a_end),
    .spi_cs_n             (a_cs_n),
    .spi_sck              (a_sck),
    .spi_mosi             (a_mosi),
    .spi_miso             (miso),
    .stream_abort         (a_abort)
  );

  flash_bitstream_streamer #(
    .BITSTREAM_BITS(32'd1)
  ) dut_b (
    .clk                  (clk),
    .reset                (reset),
    .store_flash_command  (store),
    .read_bitstream       (rd),
    .prog_chan_in_progress(prog),
    .bitstream            (b_bit),
    .end_bitstream        (b_end),
    .spi_cs_n             (b_cs_n),
    .spi_sck              (b_sck),
    .spi_mosi             (b_mosi),
    .spi_miso             (miso),
    .stream_abort         (b_abort)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Flash: capture command on sck rise, emit data on sck fall.
  always begin
    @(negedge clk);
    #1;
    if (a_cs_n) begin
      ncap = 0;
      didx = 0;
    end else if (a_sck && ncap < 32) begin
      fcmd = {fcmd[30:0], a_mosi};
      ncap++;
      if (ncap == 32) check("flash_cmd", fcmd, CMD_WORD);
    end
    @(posedge clk);
    #1;
    if (!a_cs_n && ncap == 32) begin
      miso = (didx < 16) ? fdata[15-didx] : 1'b1;
      didx++;
    end
  end

  // k counts clk edges from the one that first sees read high.
  function automatic logic exp_cs(int k, int n);
    return (k <= 32 + n) ? 1'b0 : 1'b1;
  endfunction

  function automatic logic exp_bit(int k, int n);
    if (k >= 33 && k < 33 + n) return fdata[48-k];
    return 1'b1;
  endfunction

  function automatic logic exp_end(int k, int n);
    return (k == 32 + n);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int ab_k, input bit use_prog,
                     input int st_k, input bit chk_b);
    store = 1'b1;
    prog  = 1'b1;
    step();
    store = 1'b0;
    rd    = 1'b1;
    for (int k = 0; k <= 52; k++) begin
      step();
      if (ab_k >= 0 && k > ab_k) begin
        check("ab_cs", 32'(a_cs_n), 32'd1);
        check("ab_bit", 32'(a_bit), 32'd1);
        check("ab_end", 32'(a_end), 32'd0);
        check("ab_flag", 32'(a_abort), 32'd1);
      end else begin
        check("a_cs", 32'(a_cs_n), 32'(exp_cs(k, 16)));
        check("a_bit", 32'(a_bit), 32'(exp_bit(k, 16)));
        check("a_end", 32'(a_end), 32'(exp_end(k, 16)));
        check("a_abort", 32'(a_abort), 32'd0);
        if (k < 32) check("a_mosi", 32'(a_mosi), 32'(cmdw[31-k]));
      end
      if (chk_b) begin
        check("b_cs", 32'(b_cs_n), 32'(exp_cs(k, 1)));
        check("b_bit", 32'(b_bit), 32'(exp_bit(k, 1)));
        check("b_end", 32'(b_end), 32'(exp_end(k, 1)));
        if (k < 32) check("b_mosi", 32'(b_mosi), 32'(cmdw[31-k]));
      end
      store = (k == st_k);
      if (k == ab_k) begin
        if (use_prog) prog = 1'b0;
        else rd = 1'b0;
      end
    end
    rd    = 1'b0;
    prog  = 1'b1;
    store = 1'b0;
    step();
    step();
    step();
  endtask

  initial begin
    reset = 1'b1;
    store = 1'b0;
    rd    = 1'b0;
    prog  = 1'b0;
    #12;
    check("rst_cs", 32'(a_cs_n), 32'd1);
    check("rst_bit", 32'(a_bit), 32'd1);
    check("rst_end", 32'(a_end), 32'd0);
    check("rst_mosi", 32'(a_mosi), 32'd0);
    check("rst_abort", 32'(a_abort), 32'd0);
    check("rst_sck", 32'(a_sck | b_sck), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    step();

    run(-1, 1'b0, -1, 1'b1);

    fdata = 16'($urandom);
    run(-1, 1'b0, int'($urandom_range(30, 1)), 1'b1);

    fdata = 16'($urandom);
    run(37, 1'b0, -1, 1'b0);

    fdata = 16'($urandom);
    run(47, 1'b0, -1, 1'b0);

    fdata = 16'($urandom);
    run(int'($urandom_range(46, 0)),
        1'($urandom_range(1, 0)), -1, 1'b0);

    store = 1'b1;
    prog  = 1'b1;
    step();
    store = 1'b0;
    prog  = 1'b0;
    step();
    check("armed_abort", 32'(a_abort), 32'd1);
    check("armed_cs", 32'(a_cs_n), 32'd1);
    prog = 1'b1;
    step();
    check("abort_sticky", 32'(a_abort), 32'd1);
    store = 1'b1;
    step();
    store = 1'b0;
    check("abort_clear", 32'(a_abort), 32'd0);
    fdata = 16'($urandom);
    run(-1, 1'b0, -1, 1'b1);

    fdata = 16'($urandom);
    store = 1'b1;
    prog  = 1'b1;
    step();
    store = 1'b0;
    rd    = 1'b1;
    for (int k = 0; k <= 40; k++) step();
    check("pre_rst_bit", 32'(a_bit), 32'(fdata[8]));
    #5;
    check("pre_rst_sck", 32'(a_sck), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_cs", 32'(a_cs_n), 32'd1);
    check("mid_rst_bit", 32'(a_bit), 32'd1);
    check("mid_rst_end", 32'(a_end), 32'd0);
    check("mid_rst_sck", 32'(a_sck), 32'd0);
    #1;
    reset = 1'b0;
    rd    = 1'b0;
    step();
    fdata = 16'($urandom);
    run(-1, 1'b0, -1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
